// File: rtl/cpu_pkg.sv
// Shared CPU types: NZCV flag bundle and exception FSM encoding.
// Also used by the condition tester for flags_t.
package cpu_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    EXC_NORM = 1'b0,
    EXC_EXC  = 1'b1
  } exc_state_t;

endpackage

// File: rtl/flag_status_unit_flag_reg.sv
// NZCV register with async active-low reset and load enable.
// Used for the pending, architectural and saved flag copies.
module flag_reg
  import cpu_pkg::*;
#(
  parameter flags_t RST = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  flags_t d,
  output flags_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= RST;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/flag_status_unit.sv
// NZCV status flags: capture from EX, one-cycle staging, commit,
// forwarding to the condition tester, and exception save/restore.
module flag_status_unit
  import cpu_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         FWD_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       ex_valid,
  input  logic       ex_s_bit,
  input  logic       stall,
  input  logic       flush,
  input  logic       exc_entry,
  input  logic       exc_return,
  output logic       N,
  output logic       Z,
  output logic       C,
  output logic       V,
  output logic [3:0] arch_flags,
  output logic       flag_hazard,
  output logic       in_exc,
  output logic       exc_err
);

  exc_state_t state, state_nxt;
  logic       pend_v, pend_v_nxt;
  logic       err_nxt;
  logic       cap;
  logic       restore;
  logic       save;
  logic       arch_ld;
  flags_t     alu_f;
  flags_t     pend, arch, saved;
  flags_t     eff;
  flags_t     arch_d;

  assign alu_f = '{n: alu_n, z: alu_z, c: alu_c, v: alu_v};
  assign cap   = ex_valid & ex_s_bit & ~stall & ~flush;

  assign eff = (FWD_EN && pend_v) ? pend : arch;

  // Restore wins over a commit of the staged flags.
  assign arch_ld = restore | pend_v;
  assign arch_d  = restore ? saved : pend;

  flag_reg #(.RST('0)) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cap),
    .d     (alu_f),
    .q     (pend)
  );

  flag_reg #(.RST(flags_t'(RESET_FLAGS))) u_arch (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (arch_ld),
    .d     (arch_d),
    .q     (arch)
  );

  flag_reg #(.RST('0)) u_saved (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (save),
    .d     (eff),
    .q     (saved)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EXC_NORM;
      pend_v  <= 1'b0;
      exc_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend_v  <= pend_v_nxt;
      exc_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    save       = 1'b0;
    restore    = 1'b0;
    err_nxt    = 1'b0;
    pend_v_nxt = cap;
    unique case (state)
      EXC_NORM: begin
        if (exc_entry) begin
          save      = 1'b1;
          state_nxt = EXC_EXC;
        end else if (exc_return) begin
          err_nxt = 1'b1;
        end
      end
      EXC_EXC: begin
        if (exc_return) begin
          restore    = 1'b1;
          pend_v_nxt = 1'b0;
          state_nxt  = EXC_NORM;
        end else if (exc_entry) begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = EXC_NORM;
    endcase
  end

  assign N           = eff.n;
  assign Z           = eff.z;
  assign C           = eff.c;
  assign V           = eff.v;
  assign arch_flags  = arch;
  assign flag_hazard = ex_valid & ex_s_bit;
  assign in_exc      = (state == EXC_EXC);

endmodule

// File: tb/tb_flag_status_unit.sv
// Directed bench for flag_status_unit: capture, forwarding,
// stall/flush blocking, back-to-back, exception save/restore.
module tb_flag_status_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_n, alu_z, alu_c, alu_v;
  logic       ex_valid, ex_s_bit, stall, flush;
  logic       exc_entry, exc_return;
  logic       N, Z, C, V;
  logic [3:0] arch_flags;
  logic       flag_hazard, in_exc, exc_err;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] RST_F = 4'b0000;

  flag_status_unit #(
    .RESET_FLAGS (RST_F),
    .FWD_EN      (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_n       (alu_n),
    .alu_z       (alu_z),
    .alu_c       (alu_c),
    .alu_v       (alu_v),
    .ex_valid    (ex_valid),
    .ex_s_bit    (ex_s_bit),
    .stall       (stall),
    .flush       (flush),
    .exc_entry   (exc_entry),
    .exc_return  (exc_return),
    .N           (N),
    .Z           (Z),
    .C           (C),
    .V           (V),
    .arch_flags  (arch_flags),
    .flag_hazard (flag_hazard),
    .in_exc      (in_exc),
    .exc_err     (exc_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ex_valid   = 1'b0;
    ex_s_bit   = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    exc_entry  = 1'b0;
    exc_return = 1'b0;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
  endtask

  task automatic s_instr(input logic [3:0] f);
    ex_valid = 1'b1;
    ex_s_bit = 1'b1;
    {alu_n, alu_z, alu_c, alu_v} = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_nzcv(input string nm, input logic [3:0] exp);
    total++;
    if ({N, Z, C, V} !== exp) begin
      bad++;
      $display("FAIL %s nzcv got=%b exp=%b", nm, {N, Z, C, V}, exp);
    end
  endtask

  task automatic chk_arch(input string nm, input logic [3:0] exp);
    total++;
    if (arch_flags !== exp) begin
      bad++;
      $display("FAIL %s arch got=%b exp=%b", nm, arch_flags, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got,
                         input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    chk_nzcv("rst_nzcv", RST_F);
    chk_arch("rst_arch", RST_F);
    chk_bit("rst_in_exc", in_exc, 1'b0);
    chk_bit("rst_hazard", flag_hazard, 1'b0);
    chk_bit("rst_err", exc_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk_nzcv("rel_nzcv", RST_F);
    chk_arch("rel_arch", RST_F);
  endtask

  task automatic test_capture();
    s_instr(4'b0100);
    #1;
    chk_bit("cap_hazard", flag_hazard, 1'b1);
    step();
    idle();
    chk_nzcv("cap_fwd", 4'b0100);
    chk_arch("cap_arch1", 4'b0000);
    step();
    chk_arch("cap_arch2", 4'b0100);
    chk_nzcv("cap_nzcv2", 4'b0100);
  endtask

  task automatic test_stall_flush();
    s_instr(4'b1011);
    stall = 1'b1;
    #1;
    chk_bit("stall_hazard", flag_hazard, 1'b1);
    step();
    idle();
    chk_nzcv("stall_nzcv", 4'b0100);
    step();
    chk_arch("stall_arch", 4'b0100);
    s_instr(4'b1011);
    flush = 1'b1;
    #1;
    chk_bit("flush_hazard", flag_hazard, 1'b1);
    step();
    idle();
    chk_nzcv("flush_nzcv", 4'b0100);
    step();
    chk_arch("flush_arch", 4'b0100);
  endtask

  task automatic test_back_to_back();
    s_instr(4'b1000);
    step();
    chk_nzcv("b2b_1", 4'b1000);
    chk_arch("b2b_arch1", 4'b0100);
    s_instr(4'b0001);
    step();
    idle();
    chk_nzcv("b2b_2", 4'b0001);
    chk_arch("b2b_arch2", 4'b1000);
    step();
    chk_arch("b2b_arch3", 4'b0001);
  endtask

  task automatic test_exception();
    s_instr(4'b0010);
    step();
    idle();
    // Entry while 0010 is still pending; EX instr 0111 is flushed.
    s_instr(4'b0111);
    flush     = 1'b1;
    exc_entry = 1'b1;
    step();
    idle();
    chk_bit("exc_in", in_exc, 1'b1);
    chk_arch("exc_commit", 4'b0010);
    chk_nzcv("exc_noflush", 4'b0010);
    s_instr(4'b1111);
    step();
    idle();
    step();
    chk_arch("exc_s_commit", 4'b1111);
    // Return with 0101 pending: restore wins, 0101 discarded.
    s_instr(4'b0101);
    step();
    idle();
    chk_nzcv("exc_pend", 4'b0101);
    exc_return = 1'b1;
    step();
    idle();
    chk_arch("ret_arch", 4'b0010);
    chk_nzcv("ret_nzcv", 4'b0010);
    chk_bit("ret_in", in_exc, 1'b0);
    step();
    chk_arch("ret_hold", 4'b0010);
  endtask

  task automatic test_illegal();
    exc_return = 1'b1;
    step();
    idle();
    chk_bit("ill_ret_err", exc_err, 1'b1);
    chk_bit("ill_ret_in", in_exc, 1'b0);
    step();
    chk_bit("ill_ret_pulse", exc_err, 1'b0);
    exc_entry = 1'b1;
    step();
    idle();
    chk_bit("ent_err0", exc_err, 1'b0);
    chk_bit("ent_in", in_exc, 1'b1);
    s_instr(4'b1100);
    step();
    idle();
    step();
    chk_arch("ent_s", 4'b1100);
    exc_entry = 1'b1;
    step();
    idle();
    chk_bit("dbl_err", exc_err, 1'b1);
    chk_bit("dbl_in", in_exc, 1'b1);
    step();
    chk_bit("dbl_pulse", exc_err, 1'b0);
    exc_return = 1'b1;
    step();
    idle();
    chk_arch("dbl_saved", 4'b0010);
    chk_bit("dbl_ret_in", in_exc, 1'b0);
  endtask

  task automatic test_both();
    exc_entry  = 1'b1;
    exc_return = 1'b1;
    step();
    chk_bit("both_norm_in", in_exc, 1'b1);
    chk_bit("both_norm_err", exc_err, 1'b0);
    step();
    idle();
    chk_bit("both_exc_in", in_exc, 1'b0);
    chk_bit("both_exc_err", exc_err, 1'b0);
    chk_arch("both_arch", 4'b0010);
  endtask

  task automatic test_reset_in_exc();
    exc_entry = 1'b1;
    step();
    idle();
    s_instr(4'b1001);
    step();
    idle();
    chk_bit("rx_in", in_exc, 1'b1);
    chk_nzcv("rx_pend", 4'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("rx_in_rst", in_exc, 1'b0);
    chk_arch("rx_arch", RST_F);
    chk_nzcv("rx_nzcv", RST_F);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_arch("rx_hold", RST_F);
    exc_return = 1'b1;
    step();
    idle();
    chk_bit("rx_err", exc_err, 1'b1);
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #1;
    test_reset();
    test_capture();
    test_stall_flush();
    test_back_to_back();
    test_exception();
    test_illegal();
    test_both();
    test_reset_in_exc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
